// File: rtl/axi_cmd_responder_pkg.sv
// Command/status codes and responder state type shared by the responder, its
// interface users and benches.
package axi_cmd_responder_pkg;

  localparam int AXI_REG_WIDTH      = 32;
  localparam int AXI_MEM_ADDR_WIDTH = 10;

  localparam logic [31:0] CMD_NOP                = 32'd0;
  localparam logic [31:0] CMD_WRITE              = 32'd1;
  localparam logic [31:0] CMD_READ               = 32'd2;
  localparam logic [31:0] CMD_START              = 32'd3;
  localparam logic [31:0] CMD_READ_ELAPSED_CLOCK = 32'd5;

  localparam logic [31:0] STATUS_IDLE     = 32'd0;
  localparam logic [31:0] STATUS_RUNNING  = 32'd1;
  localparam logic [31:0] STATUS_ACCEPTED = 32'd2;
  localparam logic [31:0] STATUS_REJECTED = 32'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    ACCEPTED,
    REJECTED
  } responder_state_t;

  function automatic logic [31:0] status_code(input responder_state_t s);
    logic [31:0] code;
    case (s)
      RUNNING:  code = STATUS_RUNNING;
      ACCEPTED: code = STATUS_ACCEPTED;
      REJECTED: code = STATUS_REJECTED;
      default:  code = STATUS_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/axi_cmd_responder_if.sv
// Host register, memory port and engine handshake bundle of the command
// responder; slave = responder side, master = host/memory/engine side.
interface axi_cmd_responder_if #(
  parameter int REG_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 10
);

  logic [REG_WIDTH-1:0]      cmd_register;
  logic [REG_WIDTH-1:0]      address_register;
  logic [REG_WIDTH-1:0]      data_in_register;
  logic [REG_WIDTH-1:0]      start_cc_pointer_register;
  logic [REG_WIDTH-1:0]      end_cc_pointer_register;
  logic [REG_WIDTH-1:0]      status_register;
  logic [REG_WIDTH-1:0]      data_o_register;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]      mem_wdata;
  logic                      mem_we;
  logic [REG_WIDTH-1:0]      mem_rdata;
  logic                      engine_start;
  logic [REG_WIDTH-1:0]      engine_start_cc_pointer;
  logic [REG_WIDTH-1:0]      engine_end_cc_pointer;
  logic                      engine_done;
  logic                      engine_accept;

  modport slave (
    input  cmd_register, address_register, data_in_register,
           start_cc_pointer_register, end_cc_pointer_register,
           mem_rdata, engine_done, engine_accept,
    output status_register, data_o_register, mem_addr, mem_wdata, mem_we,
           engine_start, engine_start_cc_pointer, engine_end_cc_pointer
  );

  modport master (
    output cmd_register, address_register, data_in_register,
           start_cc_pointer_register, end_cc_pointer_register,
           mem_rdata, engine_done, engine_accept,
    input  status_register, data_o_register, mem_addr, mem_wdata, mem_we,
           engine_start, engine_start_cc_pointer, engine_end_cc_pointer
  );

endinterface

// File: rtl/axi_cmd_responder_cc_elapsed_counter.sv
// Elapsed engine clock counter: synchronous clear, count while enabled,
// saturates at all-ones.
module axi_cmd_responder_cc_elapsed_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/axi_cmd_responder.sv
// Decodes host register commands into memory accesses and regex engine runs.
// Optional elapsed-clock counter: define AXI_CMD_ELAPSED_CLOCK_EN.
//
//   state    | meaning
//   IDLE     | after reset, no run issued yet
//   RUNNING  | engine launched, waiting for engine_done
//   ACCEPTED | last run matched, held until next start
//   REJECTED | last run did not match, held until next start
module axi_cmd_responder
  import axi_cmd_responder_pkg::*;
#(
  parameter int REG_WIDTH      = AXI_REG_WIDTH,
  parameter int MEM_ADDR_WIDTH = AXI_MEM_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_cmd_responder_if.slave bus
);

  logic [REG_WIDTH-1:0]      cmd_q, data_q, sptr_q, eptr_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  responder_state_t          state_q, state_d;
  logic [REG_WIDTH-1:0]      status_q, status_d;
  logic [REG_WIDTH-1:0]      data_o_q, data_o_d;
  logic [REG_WIDTH-1:0]      eng_sptr_q, eng_sptr_d;
  logic [REG_WIDTH-1:0]      eng_eptr_q, eng_eptr_d;
  logic                      rd_pend_q, rd_pend_d;

  logic                      running;
  logic                      is_write, is_read, is_start, is_elapsed;
  logic                      start_go;
  logic [REG_WIDTH-1:0]      elapsed;
  logic                      addr_hi_unused;

  assign running    = (state_q == RUNNING);
  assign is_write   = (cmd_q == REG_WIDTH'(CMD_WRITE));
  assign is_read    = (cmd_q == REG_WIDTH'(CMD_READ));
  assign is_start   = (cmd_q == REG_WIDTH'(CMD_START));
  assign is_elapsed = (cmd_q == REG_WIDTH'(CMD_READ_ELAPSED_CLOCK));
  assign start_go   = is_start && !running;

  // Only the low word-address bits reach the memory.
  assign addr_hi_unused = ^bus.address_register[REG_WIDTH-1:MEM_ADDR_WIDTH];

`ifdef AXI_CMD_ELAPSED_CLOCK_EN
  axi_cmd_responder_cc_elapsed_counter #(
    .WIDTH(REG_WIDTH)
  ) u_cc_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_go),
    .enable (running),
    .count  (elapsed)
  );
`else
  assign elapsed = '0;
`endif

  always_comb begin
    state_d    = state_q;
    eng_sptr_d = eng_sptr_q;
    eng_eptr_d = eng_eptr_q;
    data_o_d   = data_o_q;
    rd_pend_d  = is_read && !running;

    case (state_q)
      RUNNING: begin
        // A coincident start request loses to completion.
        if (bus.engine_done) begin
          state_d = bus.engine_accept ? ACCEPTED : REJECTED;
        end
      end
      default: begin
        if (start_go) begin
          state_d = RUNNING;
        end
      end
    endcase

    if (start_go) begin
      eng_sptr_d = sptr_q;
      eng_eptr_d = eptr_q;
    end

    if (rd_pend_q) begin
      data_o_d = bus.mem_rdata;
    end else if (is_elapsed) begin
      data_o_d = elapsed;
    end

    status_d = REG_WIDTH'(status_code(state_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      sptr_q     <= '0;
      eptr_q     <= '0;
      state_q    <= IDLE;
      status_q   <= REG_WIDTH'(STATUS_IDLE);
      data_o_q   <= '0;
      eng_sptr_q <= '0;
      eng_eptr_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      cmd_q      <= bus.cmd_register;
      addr_q     <= bus.address_register[MEM_ADDR_WIDTH-1:0];
      data_q     <= bus.data_in_register;
      sptr_q     <= bus.start_cc_pointer_register;
      eptr_q     <= bus.end_cc_pointer_register;
      state_q    <= state_d;
      status_q   <= status_d;
      data_o_q   <= data_o_d;
      eng_sptr_q <= eng_sptr_d;
      eng_eptr_q <= eng_eptr_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign bus.status_register = status_q;
  assign bus.data_o_register = data_o_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = data_q;
  assign bus.mem_we          = is_write && !running;
  assign bus.engine_start    = start_go;

  // During the start pulse the engine sees the pointers being latched.
  assign bus.engine_start_cc_pointer = start_go ? sptr_q : eng_sptr_q;
  assign bus.engine_end_cc_pointer   = start_go ? eptr_q : eng_eptr_q;

endmodule
